// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU), one quotient bit per cycle.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes in one cycle with a zero result.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dividend;   // shifts out dividend bits, shifts in quotient bits
    logic [DATA_W-1:0] divisor;
    logic [DATA_W:0]   partial;
    logic              qneg;
    logic              rneg;

    logic              op1_neg;
    logic              op2_neg;
    logic [DATA_W-1:0] op1_abs;
    logic [DATA_W-1:0] op2_abs;
    logic [DATA_W:0]   shifted;
    logic [DATA_W+1:0] trial;
    logic              q_bit;
    logic [DATA_W:0]   partial_nxt;
    logic [DATA_W-1:0] quot_nxt;
    logic [DATA_W-1:0] quot_fix;
    logic [DATA_W-1:0] rem_fix;

    assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    assign op1_abs = op1_neg ? (~opdata1_i + ONE) : opdata1_i;
    assign op2_abs = op2_neg ? (~opdata2_i + ONE) : opdata2_i;

    // Top bit of the widened subtraction is the sign of the trial remainder.
    assign shifted     = {partial[DATA_W-1:0], dividend[DATA_W-1]};
    assign trial       = {1'b0, shifted} - {2'b00, divisor};
    assign q_bit       = ~trial[DATA_W+1];
    assign partial_nxt = q_bit ? trial[DATA_W:0] : shifted;
    assign quot_nxt    = {dividend[DATA_W-2:0], q_bit};
    assign quot_fix    = qneg ? (~quot_nxt + ONE) : quot_nxt;
    assign rem_fix     = rneg ? (~partial_nxt[DATA_W-1:0] + ONE) : partial_nxt[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            partial  <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else if (annul_i) begin
            state    <= IDLE;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i) begin
`ifdef DIV_ZERO_FAST_EN
                        if (opdata2_i == '0) begin
                            state   <= DONE;
                            ready_o <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
`else
                        state <= BUSY;
`endif
                        dividend <= op1_abs;
                        divisor  <= op2_abs;
                        qneg     <= op1_neg ^ op2_neg;
                        rneg     <= op1_neg;
                        partial  <= '0;
                        cnt      <= '0;
                    end
                end
                BUSY: begin
                    partial  <= partial_nxt;
                    dividend <= quot_nxt;
                    cnt      <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state    <= DONE;
                        result_o <= {rem_fix, quot_fix};
                        ready_o  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!start_i) begin
                        state    <= IDLE;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes expected {result, ready cycle}, monitor pops on ready.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] cur_exp = '0;
    logic        ready_q = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division truncates toward zero, % takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, q, r;
        sa  = sgn ? longint'($signed(a)) : longint'(a);
        sb_ = sgn ? longint'($signed(b)) : longint'(b);
        if (b == 0) begin
`ifdef DIV_ZERO_FAST_EN
            return 64'd0;
`else
            q = 64'h0000_0000_FFFF_FFFF;
            r = (sa < 0) ? -sa : sa;
            if (sa < 0) begin
                q = -q;
                r = -r;
            end
`endif
        end else begin
            q = sa / sb_;
            r = sa % sb_;
        end
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int unsigned latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 0) return 1;
`endif
        return 33;
    endfunction

    // Monitor: compares on the rising edge of ready, then checks hold and idle values.
    always @(negedge clk) begin
        if (!rst) begin
            if (ready_o && !ready_q) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", {63'd0, ready_o}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    cur_exp = e.res;
                    chk("result", result_o, e.res);
                    chk("latency", 64'(cyc), 64'(e.cyc));
                end
            end else if (ready_o) begin
                chk("result_hold", result_o, cur_exp);
            end else begin
                chk("idle_result_zero", result_o, 64'd0);
            end
        end
        ready_q = ready_o;
    end

    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        bit   seen;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        e.res = ref_div(sgn, a, b);
        e.cyc = cyc + latency(b);
        sb.push_back(e);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready_o) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("ready_timeout", 64'd0, 64'd1);
        repeat (hold) @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        chk("drop_ready", {63'd0, ready_o}, 64'd0);
        chk("drop_result", result_o, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        sgn;
        logic [31:0] a, b;
        int          sel;
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
        signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_result", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_div(1'b0, 32'd100, 32'd7, 3);
        do_div(1'b1, -32'sd7, 32'd2, 0);
        do_div(1'b1, 32'd7, -32'sd2, 1);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        do_div(1'b0, 32'd5, 32'd0, 2);
        do_div(1'b1, -32'sd5, 32'd0, 0);

        // start and annul together in IDLE must not start an operation
        signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd4;
        start_i = 1'b1; annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        do_div(1'b0, 32'd50, 32'd4, 0);

        // annul on the 10th BUSY cycle
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        chk("annul_ready", {63'd0, ready_o}, 64'd0);
        chk("annul_result", result_o, 64'd0);
        repeat (40) @(negedge clk);
        do_div(1'b0, 32'd9, 32'd3, 0);

        // synchronous reset mid-BUSY
        signed_div_i = 1'b1; opdata1_i = -32'sd77; opdata2_i = 32'd5; start_i = 1'b1;
        repeat (15) @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_mid_result", result_o, 64'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        for (int k = 0; k < 24; k++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            if (k % 4 == 1) a = 32'($urandom_range(0, 200));
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 15));
                3:       b = -32'($urandom_range(1, 15));
                4:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            do_div(sgn, a, b, $urandom_range(0, 2));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
